exe_stage: RTL and testbench

//  Execute stage; consumes the ID->EXE pipeline register outputs (control, PC, Val_Rn, Val_Rm, imm,

---
 rtl/exe_pkg.sv | 38 +++
 rtl/Reg.sv | 20 ++
 rtl/val2_generator.sv | 43 ++++
 rtl/exe_stage.sv | 153 +++++++++++++++
 tb/tb_exe_stage.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// Execute-stage shared definitions: ALU opcodes, shift types, SR bit
// positions and forwarding-select codes.
package exe_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  // Status register bit positions {N,Z,C,V}
  localparam int unsigned SR_N = 3;
  localparam int unsigned SR_Z = 2;
  localparam int unsigned SR_C = 1;
  localparam int unsigned SR_V = 0;

endpackage

// File: rtl/Reg.sv
// Generic enabled register with synchronous active-high reset.
module Reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over enable; otherwise load when enabled.
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/val2_generator.sv
// Builds the second ALU operand: rotated immediate, zero-extended memory
// offset, or shifted Rm.
module val2_generator
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             imm,
  input  logic             mem_en,
  input  logic [11:0]      shift_operand,
  input  logic [WIDTH-1:0] val_rm,
  output logic [WIDTH-1:0] val2
);

  logic [WIDTH-1:0]   imm_val;
  logic [2*WIDTH-1:0] rot_imm;
  logic [2*WIDTH-1:0] rot_rm;
  logic [4:0]         shamt;
  logic [WIDTH-1:0]   shifted;

  // Operand-2 selection; rotations use a doubled word so amount 0 is identity.
  always_comb begin
    imm_val = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
    rot_imm = {imm_val, imm_val} >> {shift_operand[11:8], 1'b0};
    shamt   = shift_operand[11:7];
    rot_rm  = {val_rm, val_rm} >> shamt;
    shifted = val_rm;
    case (shift_e'(shift_operand[6:5]))
      SHIFT_LSL: shifted = val_rm << shamt;
      SHIFT_LSR: shifted = val_rm >> shamt;
      SHIFT_ASR: shifted = $signed(val_rm) >>> shamt;
      SHIFT_ROR: shifted = rot_rm[WIDTH-1:0];
      default:   shifted = val_rm;
    endcase
    if (imm)
      val2 = rot_imm[WIDTH-1:0];
    else if (mem_en)
      val2 = {{(WIDTH-12){1'b0}}, shift_operand};
    else
      val2 = shifted;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2, ALU, NZCV status register,
// branch target and EXE->MEM pipeline register.
// Optional build macro: FORWARDING_EN (operand muxing via sel_src1/sel_src2).
module exe_stage
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             WB_EN_IN,
  input  logic             MEM_R_EN_IN,
  input  logic             MEM_W_EN_IN,
  input  logic             B_IN,
  input  logic             S_IN,
  input  logic [3:0]       EXE_CMD_IN,
  input  logic [WIDTH-1:0] PC_IN,
  input  logic [WIDTH-1:0] Val_Rn_IN,
  input  logic [WIDTH-1:0] Val_Rm_IN,
  input  logic             imm_IN,
  input  logic [11:0]      Shift_operand_IN,
  input  logic [23:0]      Signed_imm_24_IN,
  input  logic [3:0]       Dest_IN,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] MEM_ALU_Res,
  input  logic [WIDTH-1:0] WB_Value,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic [WIDTH-1:0] ALU_Res,
  output logic [WIDTH-1:0] Val_Rm,
  output logic [3:0]       Dest,
  output logic [3:0]       SR,
  output logic             Branch_Taken,
  output logic [WIDTH-1:0] Branch_Address
);

  localparam int unsigned PIPE_W = 3 + 4 + 2*WIDTH;

  logic [WIDTH-1:0]  src1;
  logic [WIDTH-1:0]  src2;
  logic [WIDTH-1:0]  val2;
  logic [WIDTH-1:0]  alu_res;
  logic [WIDTH-1:0]  b_op;
  logic [WIDTH:0]    sum;
  logic              cin;
  logic              arith;
  logic              flag_c;
  logic              flag_v;
  logic [3:0]        sr_next;
  logic [PIPE_W-1:0] pipe_d;
  logic [PIPE_W-1:0] pipe_q;

`ifdef FORWARDING_EN
  // Operand forwarding from MEM result or WB value.
  always_comb begin
    src1 = Val_Rn_IN;
    src2 = Val_Rm_IN;
    case (fwd_sel_e'(sel_src1))
      FWD_MEM: src1 = MEM_ALU_Res;
      FWD_WB:  src1 = WB_Value;
      default: src1 = Val_Rn_IN;
    endcase
    case (fwd_sel_e'(sel_src2))
      FWD_MEM: src2 = MEM_ALU_Res;
      FWD_WB:  src2 = WB_Value;
      default: src2 = Val_Rm_IN;
    endcase
  end
`else
  logic unused_fwd;

  // Operands straight from the ID register; forwarding inputs are unused.
  always_comb begin
    src1       = Val_Rn_IN;
    src2       = Val_Rm_IN;
    unused_fwd = ^{sel_src1, sel_src2, MEM_ALU_Res, WB_Value};
  end
`endif

  val2_generator #(.WIDTH(WIDTH)) u_val2 (
    .imm           (imm_IN),
    .mem_en        (MEM_R_EN_IN | MEM_W_EN_IN),
    .shift_operand (Shift_operand_IN),
    .val_rm        (src2),
    .val2          (val2)
  );

  // ALU: all arithmetic goes through one adder, subtraction as a + ~b + cin.
  always_comb begin
    alu_res = '0;
    b_op    = '0;
    cin     = 1'b0;
    arith   = 1'b0;
    sum     = '0;
    flag_c  = SR[SR_C];
    flag_v  = SR[SR_V];
    case (exe_cmd_e'(EXE_CMD_IN))
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_AND: alu_res = src1 & val2;
      CMD_ORR: alu_res = src1 | val2;
      CMD_EOR: alu_res = src1 ^ val2;
      CMD_ADD: begin arith = 1'b1; b_op = val2;  cin = 1'b0;     end
      CMD_ADC: begin arith = 1'b1; b_op = val2;  cin = SR[SR_C]; end
      CMD_SUB: begin arith = 1'b1; b_op = ~val2; cin = 1'b1;     end
      CMD_SBC: begin arith = 1'b1; b_op = ~val2; cin = SR[SR_C]; end
      default: alu_res = '0;
    endcase
    if (arith) begin
      sum     = {1'b0, src1} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
      alu_res = sum[WIDTH-1:0];
      flag_c  = sum[WIDTH];
      flag_v  = (src1[WIDTH-1] == b_op[WIDTH-1]) && (alu_res[WIDTH-1] != src1[WIDTH-1]);
    end
    sr_next       = '0;
    sr_next[SR_N] = alu_res[WIDTH-1];
    sr_next[SR_Z] = (alu_res == '0);
    sr_next[SR_C] = flag_c;
    sr_next[SR_V] = flag_v;
  end

  // Branch target: word offset sign-extended and scaled by 4.
  always_comb begin
    Branch_Taken   = B_IN;
    Branch_Address = PC_IN + {{(WIDTH-26){Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};
  end

  // Pack and unpack the EXE->MEM register contents.
  always_comb begin
    pipe_d = {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, Dest_IN, src2, alu_res};
    {WB_EN, MEM_R_EN, MEM_W_EN, Dest, Val_Rm, ALU_Res} = pipe_q;
  end

  Reg #(.WIDTH(PIPE_W)) u_pipe_reg (
    .clk (clk),
    .rst (rst),
    .en  (~freeze),
    .d   (pipe_d),
    .q   (pipe_q)
  );

  Reg #(.WIDTH(4)) u_sr_reg (
    .clk (clk),
    .rst (rst),
    .en  (~freeze & S_IN),
    .d   (sr_next),
    .q   (SR)
  );

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed steps plus randomized vectors
// against an arithmetic reference model.
module tb_exe_stage;

  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint MASK  = 64'h0_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN;
  logic [3:0]  EXE_CMD_IN;
  logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
  logic        imm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic [3:0]  Dest_IN;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] MEM_ALU_Res, WB_Value;
  logic        WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [3:0]  Dest, SR;
  logic        Branch_Taken;
  logic [31:0] Branch_Address;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Model state: expected registered outputs and status register
  logic [31:0] e_alu, e_rm;
  logic [3:0]  e_dest, m_sr;
  logic        e_wb, e_mr, e_mw;
  logic [31:0] held;

  always #5 clk = ~clk;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .B_IN(B_IN), .S_IN(S_IN), .EXE_CMD_IN(EXE_CMD_IN), .PC_IN(PC_IN),
    .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN), .imm_IN(imm_IN),
    .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
    .Dest_IN(Dest_IN), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .SR(SR),
    .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic longint ror32(input longint v, input int n);
    return ((v >> n) | (v << (32 - n))) & MASK;
  endfunction

  function automatic longint to_signed(input longint v);
    return (v >= 64'h8000_0000) ? v - TWO32 : v;
  endfunction

  function automatic longint val2_model(input logic [31:0] rm);
    longint r, s;
    int amt;
    r = rm;
    if (imm_IN) return ror32(longint'(Shift_operand_IN[7:0]), 2 * int'(Shift_operand_IN[11:8]));
    if (MEM_R_EN_IN || MEM_W_EN_IN) return longint'(Shift_operand_IN);
    amt = int'(Shift_operand_IN[11:7]);
    case (Shift_operand_IN[6:5])
      2'd0: return (r << amt) & MASK;
      2'd1: return r >> amt;
      2'd2: begin s = to_signed(r); return (s >>> amt) & MASK; end
      default: return ror32(r, amt);
    endcase
  endfunction

  function automatic logic [31:0] fwd_model(input logic [1:0] sel, input logic [31:0] reg_val);
`ifdef FORWARDING_EN
    if (sel == 2'b01) return MEM_ALU_Res;
    if (sel == 2'b10) return WB_Value;
`endif
    if (sel == 2'bxx) return reg_val;
    return reg_val;
  endfunction

  // One cycle: check combinational branch outputs, clock, update model, check registers.
  task automatic step();
    longint a, b, r, sa, sb, sr_true, off, addr, cin;
    logic [31:0] rm_f, res;
    logic c, v;
    rm_f = fwd_model(sel_src2, Val_Rm_IN);
    a    = longint'(fwd_model(sel_src1, Val_Rn_IN));
    b    = val2_model(rm_f);
    sa   = to_signed(a);
    sb   = to_signed(b);
    cin  = m_sr[1] ? 1 : 0;
    c    = m_sr[1];
    v    = m_sr[0];
    r    = 0;
    case (EXE_CMD_IN)
      4'd1: r = b;
      4'd9: r = (~b) & MASK;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        if (EXE_CMD_IN == 4'd2) cin = 0;
        r = a + b + cin;
        c = (r >= TWO32);
        sr_true = sa + sb + cin;
        v = (sr_true > 64'sh7FFF_FFFF) || (sr_true < -64'sh8000_0000);
        r = r & MASK;
      end
      4'd4, 4'd5: begin
        if (EXE_CMD_IN == 4'd4) cin = 1;
        c = (a >= b + (1 - cin));
        r = (a - b - (1 - cin)) & MASK;
        sr_true = sa - sb - (1 - cin);
        v = (sr_true > 64'sh7FFF_FFFF) || (sr_true < -64'sh8000_0000);
      end
      default: r = 0;
    endcase
    res  = r[31:0];
    off  = longint'(Signed_imm_24_IN);
    if (Signed_imm_24_IN[23]) off = off - 64'h100_0000;
    addr = (longint'(PC_IN) + off * 4) & MASK;
    #1;
    chk("branch_taken", {31'b0, Branch_Taken}, {31'b0, B_IN});
    chk("branch_addr", Branch_Address, addr[31:0]);
    @(posedge clk);
    #1;
    if (rst) begin
      e_alu = '0; e_rm = '0; e_dest = '0; e_wb = 1'b0; e_mr = 1'b0; e_mw = 1'b0; m_sr = '0;
    end else if (!freeze) begin
      e_alu = res; e_rm = rm_f; e_dest = Dest_IN;
      e_wb = WB_EN_IN; e_mr = MEM_R_EN_IN; e_mw = MEM_W_EN_IN;
      if (S_IN) m_sr = {res[31], res == 32'd0, c, v};
    end
    chk("alu_res", ALU_Res, e_alu);
    chk("val_rm", Val_Rm, e_rm);
    chk("dest", {28'b0, Dest}, {28'b0, e_dest});
    chk("ctrl", {29'b0, WB_EN, MEM_R_EN, MEM_W_EN}, {29'b0, e_wb, e_mr, e_mw});
    chk("sr", {28'b0, SR}, {28'b0, m_sr});
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic s, input logic im,
                        input logic [11:0] op, input logic [31:0] rn, input logic [31:0] rm);
    EXE_CMD_IN = cmd; S_IN = s; imm_IN = im; Shift_operand_IN = op;
    Val_Rn_IN = rn; Val_Rm_IN = rm;
    MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0; WB_EN_IN = 1'b1; B_IN = 1'b0;
    sel_src1 = 2'b00; sel_src2 = 2'b00;
  endtask

  initial begin
    m_sr = '0; e_alu = '0; e_rm = '0; e_dest = '0; e_wb = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
    // Reset with nonzero inputs and freeze asserted: reset wins
    rst = 1'b1; freeze = 1'b1;
    set_op(4'd2, 1'b1, 1'b1, 12'h0FF, 32'h1234_5678, 32'hDEAD_BEEF);
    MEM_R_EN_IN = 1'b1; Dest_IN = 4'hA; PC_IN = 32'h40; Signed_imm_24_IN = 24'h000010;
    MEM_ALU_Res = 32'h10; WB_Value = 32'h20;
    step();
    step();
    chk("reset_alu", ALU_Res, 32'h0);
    chk("reset_sr", {28'b0, SR}, 32'h0);
    rst = 1'b0; freeze = 1'b0;

    // ADD overflow into sign bit
    set_op(4'd2, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0); Dest_IN = 4'd3;
    step();
    chk("add_ovf_res", ALU_Res, 32'h8000_0000);
    chk("add_ovf_sr", {28'b0, SR}, 32'h9);

    // SUB to zero, then ADC consumes carry
    set_op(4'd4, 1'b1, 1'b1, 12'h005, 32'd5, 32'h0);
    step();
    chk("sub_zero_res", ALU_Res, 32'h0);
    chk("sub_zero_sr", {28'b0, SR}, 32'h6);
    set_op(4'd3, 1'b1, 1'b1, 12'h001, 32'd1, 32'h0);
    step();
    chk("adc_res", ALU_Res, 32'd3);

    // MOV rotated immediate, S=0 holds SR; then ASR of Rm
    held = {28'b0, m_sr};
    set_op(4'd1, 1'b0, 1'b1, 12'h4FF, 32'h0, 32'h0);
    step();
    chk("mov_imm_res", ALU_Res, 32'hFF00_0000);
    chk("mov_sr_held", {28'b0, SR}, held);
    set_op(4'd1, 1'b0, 1'b0, 12'h240, 32'h0, 32'h8000_0000);
    step();
    chk("asr_res", ALU_Res, 32'hF800_0000);

    // Freeze for three cycles with changing inputs; branch still tracks
    held = ALU_Res;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(4'd2, 1'b1, 1'b0, 12'($urandom), $urandom, $urandom);
      B_IN = 1'b1; PC_IN = 32'h100; Signed_imm_24_IN = 24'hFFFFFF;
      step();
      chk("freeze_hold", ALU_Res, held);
      chk("branch_back", Branch_Address, 32'hFC);
    end
    freeze = 1'b0;

    // Forwarded Rn from MEM result
    set_op(4'd2, 1'b0, 1'b1, 12'h001, 32'h55, 32'h0);
    sel_src1 = 2'b01; MEM_ALU_Res = 32'h10;
    step();
`ifdef FORWARDING_EN
    chk("fwd_add", ALU_Res, 32'h11);
`else
    chk("fwd_add", ALU_Res, 32'h56);
`endif

    // Randomized vectors against the model
    for (int i = 0; i < 400; i++) begin
      rst              = ($urandom_range(0, 49) == 0);
      freeze           = ($urandom_range(0, 4) == 0);
      WB_EN_IN         = 1'($urandom);
      MEM_R_EN_IN      = ($urandom_range(0, 5) == 0);
      MEM_W_EN_IN      = ($urandom_range(0, 5) == 0);
      B_IN             = 1'($urandom);
      S_IN             = 1'($urandom);
      EXE_CMD_IN       = 4'($urandom_range(0, 15));
      PC_IN            = $urandom;
      Val_Rn_IN        = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      Val_Rm_IN        = $urandom;
      imm_IN           = 1'($urandom);
      Shift_operand_IN = 12'($urandom);
      Signed_imm_24_IN = 24'($urandom);
      Dest_IN          = 4'($urandom);
      sel_src1         = 2'($urandom);
      sel_src2         = 2'($urandom);
      MEM_ALU_Res      = $urandom;
      WB_Value         = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
